gray_step_monitor: RTL

//  Downstream consumer of the 3-bit Gray-code state counter. Samples the counter

---
 rtl/gray_mon_pkg.sv | 26 ++
 rtl/gray_to_bin.sv | 19 +
 rtl/gray_step_monitor.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-code step monitor.
// Optional feature macro: GRAY_MON_REVERSE_EN (see gray_step_monitor).
package gray_mon_pkg;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  typedef enum logic [1:0] {HOLD, FWD, REV, ILLEGAL} step_t;

  // Width of the clean-step counter; holds LOCK_N up to 15.
  localparam int GOOD_W = 4;

  // Gray to binary: XOR prefix from the MSB down. Upper unused bits stay zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  // Binary to Gray: adjacent-bit XOR.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit Gray to binary decoder.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray_to_bin
  import gray_mon_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: decodes sampled Gray counts, classifies each step,
// tracks lock, counts revolutions and illegal steps.
// Optional macro GRAY_MON_REVERSE_EN: reverse steps become legal, reverse wraps
// decrement cyc_cnt, and a 'dir' output reports the last non-hold direction.
module gray_step_monitor
  import gray_mon_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 4,
  parameter int CYC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             locked,
  output logic             step_err,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic [CYC_W-1:0] err_cnt
`ifdef GRAY_MON_REVERSE_EN
  ,
  output logic             dir
`endif
);

`ifdef GRAY_MON_REVERSE_EN
  localparam bit REV_LEGAL = 1'b1;
`else
  localparam bit REV_LEGAL = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_BIN = '1;
  localparam logic [CYC_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  b_dec;
  logic [WIDTH-1:0]  p_plus;
  logic [WIDTH-1:0]  p_minus;
  logic              fwd_wrap;
  logic              rev_wrap;
  step_t             step_cls;
  state_t            state_reg, state_next;
  logic [GOOD_W-1:0] good_reg, good_next, good_inc;
  logic [WIDTH-1:0]  bin_reg, bin_next;
  logic              step_err_reg, step_err_next;
  logic [CYC_W-1:0]  cyc_reg, cyc_next;
  logic [CYC_W-1:0]  err_reg, err_next;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (b_dec)
  );

  assign p_plus   = bin_reg + WIDTH'(1);
  assign p_minus  = bin_reg - WIDTH'(1);
  assign fwd_wrap = (bin_reg == MAX_BIN) && (b_dec == '0);
  assign rev_wrap = (bin_reg == '0) && (b_dec == MAX_BIN);

  // Classify the new sample against the previous decoded value
  always_comb begin
    step_cls = ILLEGAL;
    if (b_dec == bin_reg)      step_cls = HOLD;
    else if (b_dec == p_plus)  step_cls = FWD;
    else if (b_dec == p_minus) step_cls = REV;
  end

  // Next-state logic: FSM, clean-step counter, error pulse and counters
  always_comb begin
    state_next    = state_reg;
    good_next     = good_reg;
    bin_next      = bin_reg;
    step_err_next = 1'b0;
    cyc_next      = cyc_reg;
    err_next      = err_reg;
    good_inc      = good_reg + GOOD_W'(1);

    if (sample_en) begin
      // Always resync to the latest sample, even on an error.
      bin_next = b_dec;
      case (state_reg)
        SEARCH: begin
          good_next  = '0;
          state_next = TRACK;
        end
        TRACK: begin
          if (step_cls == FWD || (REV_LEGAL && step_cls == REV)) begin
            good_next = good_inc;
            if (good_inc == GOOD_W'(LOCK_N)) state_next = LOCKED;
          end else if (step_cls != HOLD) begin
            step_err_next = 1'b1;
            good_next     = '0;
            if (err_reg != CNT_MAX) err_next = err_reg + CYC_W'(1);
          end
        end
        LOCKED: begin
          if (step_cls == FWD) begin
            if (fwd_wrap) cyc_next = cyc_reg + CYC_W'(1);
          end else if (REV_LEGAL && step_cls == REV) begin
            if (rev_wrap) cyc_next = cyc_reg - CYC_W'(1);
          end else if (step_cls != HOLD) begin
            step_err_next = 1'b1;
            good_next     = '0;
            state_next    = TRACK;
            if (err_reg != CNT_MAX) err_next = err_reg + CYC_W'(1);
          end
        end
        default: state_next = SEARCH;
      endcase
    end

    // Clear has priority over any same-cycle wrap or error increment.
    if (clear) begin
      cyc_next = '0;
      err_next = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= SEARCH;
      good_reg     <= '0;
      bin_reg      <= '0;
      step_err_reg <= 1'b0;
      cyc_reg      <= '0;
      err_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      good_reg     <= good_next;
      bin_reg      <= bin_next;
      step_err_reg <= step_err_next;
      cyc_reg      <= cyc_next;
      err_reg      <= err_next;
    end
  end

  assign bin_out  = bin_reg;
  assign locked   = (state_reg == LOCKED);
  assign step_err = step_err_reg;
  assign cyc_cnt  = cyc_reg;
  assign err_cnt  = err_reg;

`ifdef GRAY_MON_REVERSE_EN
  logic dir_reg;

  // Remember the direction of the last forward/reverse step once tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_reg <= 1'b0;
    end else if (sample_en && state_reg != SEARCH) begin
      if (step_cls == FWD)      dir_reg <= 1'b0;
      else if (step_cls == REV) dir_reg <= 1'b1;
    end
  end

  assign dir = dir_reg;
`endif

endmodule
